// File: rtl/xor_hpc2_pipe.sv
// xor_hpc2_pipe: share-wise masked XOR (HPC2 linear gadget) with N shares of
// W bits each, followed by LAT elastic valid/ready register stages.
// Share i of the result depends only on share i of each operand. The linear
// gadget therefore never combines shares.
// Optional build macro XOR_HPC2_PIPE_REFRESH_EN adds an rnd port. With it set,
// stage 0 applies a ring refresh: r_i ^ r_{(i+1) mod N} is added to share i.
// The refresh needs LAT >= 1.
module xor_hpc2_pipe #(
    parameter int N   = 3,
    parameter int W   = 1,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
`ifdef XOR_HPC2_PIPE_REFRESH_EN
    input  logic [N*W-1:0] rnd,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] c,
    output logic           out_valid,
    input  logic           out_ready
);

    if (N < 2 || LAT < 0 || LAT > 8) begin : g_bad_param
        $error("xor_hpc2_pipe: N must be >= 2 and LAT must be in 0..8");
    end

    // Share-wise combination. Each share only sees its own operand slices.
    // The refresh mask ring is the only place where two indices meet, and it
    // only touches fresh randomness.
    logic [N*W-1:0] mix;

    for (genvar i = 0; i < N; i++) begin : g_share
`ifdef XOR_HPC2_PIPE_REFRESH_EN
        assign mix[i*W +: W] = a[i*W +: W] ^ b[i*W +: W]
                             ^ rnd[i*W +: W] ^ rnd[((i+1)%N)*W +: W];
`else
        assign mix[i*W +: W] = a[i*W +: W] ^ b[i*W +: W];
`endif
    end

    if (LAT == 0) begin : g_comb
`ifdef XOR_HPC2_PIPE_REFRESH_EN
        $error("xor_hpc2_pipe: ring refresh requires LAT >= 1");
`endif
        // Pure pass-through. The clock is intentionally unused here.
        logic unused_clk;
        assign unused_clk = clk;
        assign c          = mix;
        assign out_valid  = in_valid;
        assign in_ready   = out_ready & ~rst;
    end else begin : g_pipe
        logic [LAT-1:0][N*W-1:0] data_p;
        logic [LAT-1:0]          vld_p;
        logic [LAT-1:0][N*W-1:0] up_data;
        logic [LAT-1:0]          up_vld;
        logic [LAT-1:0]          stage_ready;
        logic                    rdy_acc;

        // Ready ripples back from the output. An empty stage is always
        // ready, so bubbles collapse even while the output stalls.
        always_comb begin
            rdy_acc     = out_ready;
            stage_ready = '0;
            for (int k = LAT - 1; k >= 0; k--) begin
                rdy_acc        = ~vld_p[k] | rdy_acc;
                stage_ready[k] = rdy_acc;
            end
            up_vld[0]  = in_valid;
            up_data[0] = mix;
            for (int k = 1; k < LAT; k++) begin
                up_vld[k]  = vld_p[k-1];
                up_data[k] = data_p[k-1];
            end
        end

        // Stage k captures its upstream slot whenever it is ready.
        // Reset clears data as well, so no share value survives a reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p  <= '0;
                data_p <= '0;
            end else begin
                for (int k = 0; k < LAT; k++) begin
                    if (stage_ready[k]) begin
                        vld_p[k]  <= up_vld[k];
                        data_p[k] <= up_data[k];
                    end
                end
            end
        end

        assign c         = data_p[LAT-1];
        assign out_valid = vld_p[LAT-1];
        assign in_ready  = stage_ready[0] & ~rst;
    end

endmodule

// File: tb/tb_xor_hpc2_pipe.sv
// Testbench for xor_hpc2_pipe. Instances under test:
//   u1: N=3 W=1 LAT=1 (directed test plus randomized backpressure)
//   u2: N=4 W=8 LAT=2 (streaming, stall, reset with items in flight)
//   u0: N=4 W=8 LAT=0 (combinational pass-through, default build only)
//   ur: N=3 W=4 LAT=1 with ring refresh (XOR_HPC2_PIPE_REFRESH_EN only)
// A scoreboard queue per pipelined instance receives a^b at each input
// handshake. The monitors pop and compare at each output handshake.
module tb_xor_hpc2_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] v;
        logic [63:0] um;
        int          cyc;
    } item_t;

    // ---------------- u1 : N=3 W=1 LAT=1 ----------------
    logic [2:0] a1 = '0, b1 = '0, c1;
    logic iv1 = 1'b0, ir1, ov1, or1 = 1'b1;
    xor_hpc2_pipe #(.N(3), .W(1), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
`ifdef XOR_HPC2_PIPE_REFRESH_EN
        .rnd(3'b000),
`endif
        .in_valid(iv1), .in_ready(ir1), .c(c1), .out_valid(ov1), .out_ready(or1));

    // ---------------- u2 : N=4 W=8 LAT=2 ----------------
    logic [31:0] a2 = '0, b2 = '0, c2;
    logic iv2 = 1'b0, ir2, ov2, or2 = 1'b1;
    xor_hpc2_pipe #(.N(4), .W(8), .LAT(2)) u2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2),
`ifdef XOR_HPC2_PIPE_REFRESH_EN
        .rnd(32'h0),
`endif
        .in_valid(iv2), .in_ready(ir2), .c(c2), .out_valid(ov2), .out_ready(or2));

`ifndef XOR_HPC2_PIPE_REFRESH_EN
    // ---------------- u0 : N=4 W=8 LAT=0 ----------------
    logic [31:0] a0 = '0, b0 = '0, c0;
    logic iv0 = 1'b0, ir0, ov0, or0 = 1'b1;
    xor_hpc2_pipe #(.N(4), .W(8), .LAT(0)) u0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0),
        .in_valid(iv0), .in_ready(ir0), .c(c0), .out_valid(ov0), .out_ready(or0));
`else
    // ---------------- ur : N=3 W=4 LAT=1, refresh ----------------
    logic [11:0] ar = '0, br = '0, rr = '0, cr;
    logic ivr = 1'b0, irr, ovr, orr = 1'b1;
    xor_hpc2_pipe #(.N(3), .W(4), .LAT(1)) ur (
        .clk(clk), .rst(rst), .a(ar), .b(br), .rnd(rr),
        .in_valid(ivr), .in_ready(irr), .c(cr), .out_valid(ovr), .out_ready(orr));
`endif

    // Unmasked value: XOR of all n shares of width w.
    function automatic logic [63:0] unmask(input logic [63:0] x, input int n, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r ^= (x >> (i * w)) & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- scoreboards / monitors ----------------
    item_t q1[$];
    item_t q2[$];
    item_t e1, e2;
    logic  lat_chk2 = 1'b0;
    logic  p1_ov = 1'b0, p1_fire = 1'b0;
    logic  p2_ov = 1'b0, p2_fire = 1'b0;
    logic [2:0]  p1_c = '0;
    logic [31:0] p2_c = '0;

    // u1 monitor: hold checks while stalled, pop on output handshake, push on input handshake
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            p1_ov   = 1'b0;
            p1_fire = 1'b0;
        end else begin
            if (p1_ov && !p1_fire) begin
                check("u1_hold_valid", ov1, 1'b1);
                check("u1_hold_data", c1, p1_c);
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) fail_now("u1_unexpected_out", "output with empty scoreboard");
                else begin
                    e1 = q1.pop_front();
                    check("u1_data", c1, e1.v);
                    check("u1_unmasked", unmask(c1, 3, 1), e1.um);
                end
            end
            if (iv1 && ir1) begin
                e1.v   = a1 ^ b1;
                e1.um  = unmask(a1, 3, 1) ^ unmask(b1, 3, 1);
                e1.cyc = cyc;
                q1.push_back(e1);
            end
            p1_ov   = ov1;
            p1_fire = ov1 && or1;
            p1_c    = c1;
        end
    end

    // u2 monitor: same as u1, plus exact latency during free-flowing streaming
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            p2_ov   = 1'b0;
            p2_fire = 1'b0;
        end else begin
            if (p2_ov && !p2_fire) begin
                check("u2_hold_valid", ov2, 1'b1);
                check("u2_hold_data", c2, p2_c);
            end
            if (ov2 && or2) begin
                if (q2.size() == 0) fail_now("u2_unexpected_out", "output with empty scoreboard");
                else begin
                    e2 = q2.pop_front();
                    check("u2_data", c2, e2.v);
                    check("u2_unmasked", unmask(c2, 4, 8), e2.um);
                    if (lat_chk2) check("u2_latency", cyc - e2.cyc, 2);
                end
            end
            if (iv2 && ir2) begin
                e2.v   = a2 ^ b2;
                e2.um  = unmask(a2, 4, 8) ^ unmask(b2, 4, 8);
                e2.cyc = cyc;
                q2.push_back(e2);
            end
            p2_ov   = ov2;
            p2_fire = ov2 && or2;
            p2_c    = c2;
        end
    end

    // ---------------- drivers ----------------
    task automatic send1(input logic [2:0] av, input logic [2:0] bv, input bit rnd_or);
        bit acc;
        int t;
        a1 = av; b1 = bv; iv1 = 1'b1;
        acc = 1'b0; t = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = ir1;
            @(posedge clk); #1;
            if (rnd_or) or1 = ($urandom_range(0, 3) != 0);
            t++;
        end
        iv1 = 1'b0;
        if (!acc) fail_now("u1_send_timeout", "input never accepted");
    endtask

    task automatic send2(input logic [31:0] av, input logic [31:0] bv);
        bit acc;
        int t;
        a2 = av; b2 = bv; iv2 = 1'b1;
        acc = 1'b0; t = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = ir2;
            @(posedge clk); #1;
            t++;
        end
        iv2 = 1'b0;
        if (!acc) fail_now("u2_send_timeout", "input never accepted");
    endtask

    task automatic drain(input int which);
        int t;
        t = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check((which == 1) ? "u1_drain" : "u2_drain",
              (which == 1) ? q1.size() : q2.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int acc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_u1_out_valid", ov1, 1'b0);
        check("rst_u1_c", c1, 3'b000);
        check("rst_u1_in_ready", ir1, 1'b0);
        check("rst_u2_out_valid", ov2, 1'b0);
        check("rst_u2_c", c2, 32'h0);
        check("rst_u2_in_ready", ir2, 1'b0);
`ifndef XOR_HPC2_PIPE_REFRESH_EN
        check("rst_u0_in_ready", ir0, 1'b0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_u1_in_ready", ir1, 1'b1);
        check("post_rst_u2_in_ready", ir2, 1'b1);

        // u1 directed: 101 ^ 011 = 110, unmasked 0 ^ 0 = 0
        a1 = 3'b101; b1 = 3'b011; iv1 = 1'b1; or1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        check("u1_directed_valid", ov1, 1'b1);
        check("u1_directed_c", c1, 3'b110);
        check("u1_directed_unmasked", unmask(c1, 3, 1), 0);
        @(posedge clk); #1;

        // u1 random operands with random output backpressure
        for (int i = 0; i < 25; i++) send1(3'($urandom), 3'($urandom), 1'b1);
        or1 = 1'b1;
        drain(1);

        // u2 back-to-back streaming at full rate
        lat_chk2 = 1'b1;
        or2 = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 30; i++) send2($urandom, $urandom);
        check("u2_throughput_cycles", cyc - t0, 30);
        drain(2);
        lat_chk2 = 1'b0;

        // u2 stall: two accepts fill the pipe, then in_ready drops
        or2 = 1'b0;
        a2 = $urandom; b2 = $urandom; iv2 = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("u2_bp_in_ready", ir2, (k < 2) ? 1'b1 : 1'b0);
            if (ir2) acc++;
            @(posedge clk); #1;
            if (ir2 == 1'b0 && acc == k + 1) begin
                a2 = $urandom; b2 = $urandom;
            end
        end
        iv2 = 1'b0;
        check("u2_bp_accepts", acc, 2);
        check("u2_bp_queued", q2.size(), 2);
        or2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("u2_release_in_ready", ir2, 1'b1);
        check("u2_release_out_valid", ov2, 1'b0);
        check("u2_release_queue", q2.size(), 0);

        // u2 reset with two items in flight
        or2 = 1'b0;
        send2($urandom, $urandom);
        send2($urandom, $urandom);
        check("u2_inflight_valid", ov2, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("u2_rst_out_valid", ov2, 1'b0);
        check("u2_rst_c", c2, 32'h0);
        check("u2_rst_in_ready", ir2, 1'b0);
        rst = 1'b0;
        #1;
        check("u2_after_rst_in_ready", ir2, 1'b1);
        or2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("u2_no_stale_valid", ov2, 1'b0);
            @(posedge clk); #1;
        end

`ifndef XOR_HPC2_PIPE_REFRESH_EN
        // u0: combinational pass-through
        for (int k = 0; k < 12; k++) begin
            a0 = $urandom; b0 = $urandom;
            iv0 = 1'($urandom); or0 = (k % 2 == 0);
            #1;
            check("u0_c", c0, a0 ^ b0);
            check("u0_in_ready", ir0, or0);
            check("u0_out_valid", ov0, iv0);
            @(posedge clk); #1;
        end
`else
        // ur: ring refresh at stage-0 capture
        ar = 12'h123; br = 12'h000; rr = 12'hFA5; ivr = 1'b1; orr = 1'b1;
        @(posedge clk); #1;
        ivr = 1'b0;
        rr  = 12'h000;
        check("ur_valid", ovr, 1'b1);
        check("ur_share0", cr[3:0],  4'h3 ^ 4'h5 ^ 4'hA);
        check("ur_share1", cr[7:4],  4'h2 ^ 4'hA ^ 4'hF);
        check("ur_share2", cr[11:8], 4'h1 ^ 4'hF ^ 4'h5);
        check("ur_unmasked", unmask(cr, 3, 4), 0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
